// File: rtl/conv_engine_arbiter.sv
// Round-robin arbiter sharing one conv2d engine between NUM_REQ job requesters.
// Each accepted job re-resets the engine for one cycle, runs to done or timeout, then returns a tagged response.
`timescale 1ns/1ps

module conv_engine_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int KERNEL_SIZE  = 3,
    parameter int WEIGHT_WIDTH = 8,
    parameter int TAG_W        = 4,
    parameter int TIMEOUT_CYC  = 1024,
    localparam int FW   = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*FW-1:0]    req_filter,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     eng_rst,
    output logic [FW-1:0]            eng_filter,
    input  logic                     eng_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              grant_vld;
    logic [FW-1:0]     sel_filter;
    logic [TAG_W-1:0]  sel_tag;
    logic [CNT_W-1:0]  run_cnt;
    logic              handshake;
    logic              timed_out;
    int                scan_idx;

    // Scan from farthest to nearest after rr_ptr so the nearest valid requester wins.
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        grant      = '0;
        grant_vld  = 1'b0;
        sel_filter = '0;
        sel_tag    = '0;
        scan_idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[scan_idx]) begin
                grant      = ID_W'(scan_idx);
                grant_vld  = 1'b1;
                sel_filter = req_filter[scan_idx*FW +: FW];
                sel_tag    = req_tag[scan_idx*TAG_W +: TAG_W];
            end
        end
    end

    assign handshake = (state == IDLE) && grant_vld;
    assign timed_out = (run_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_rst   = 1'b1;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = LOAD;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                eng_rst = 1'b0;
                if (eng_done || timed_out) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= ID_W'(NUM_REQ - 1);
            eng_filter <= '0;
            rsp_id     <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            run_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                eng_filter <= sel_filter;
                rsp_id     <= grant;
                rsp_tag    <= sel_tag;
                rr_ptr     <= grant;
            end
            if (state == LOAD) run_cnt <= '0;
            if (state == RUN) begin
                run_cnt <= run_cnt + 1'b1;
                // Done wins over a simultaneous timeout.
                if (eng_done)       rsp_err <= 1'b0;
                else if (timed_out) rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Randomized bench for conv_engine_arbiter: job-level reference model for grant order,
// response latency, timeout and tag/filter routing, plus a simple engine model.
`timescale 1ns/1ps

module tb_conv_engine_arbiter;

    localparam int NUM_REQ = 4;
    localparam int KS      = 3;
    localparam int WW      = 8;
    localparam int TAG_W   = 4;
    localparam int TO      = 16;
    localparam int FW      = KS * KS * WW;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*FW-1:0]    req_filter;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     eng_rst;
    logic [FW-1:0]            eng_filter;
    logic                     eng_done;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     rsp_err;
    logic                     busy;

    conv_engine_arbiter #(
        .NUM_REQ(NUM_REQ), .KERNEL_SIZE(KS), .WEIGHT_WIDTH(WW),
        .TAG_W(TAG_W), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_filter(req_filter), .req_tag(req_tag),
        .eng_rst(eng_rst), .eng_filter(eng_filter), .eng_done(eng_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine model: raises done in its done_n-th cycle out of reset (done_n=0 never finishes).
    int   done_n     = 0;
    logic force_done = 1'b0;
    int   eng_cycles = 0;
    always @(posedge clk) eng_cycles <= eng_rst ? 0 : eng_cycles + 1;
    assign eng_done = force_done | (!eng_rst && done_n > 0 && eng_cycles >= done_n - 1);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model state: last granted requester.
    int               m_ptr = NUM_REQ - 1;
    logic [FW-1:0]    flt [NUM_REQ];
    logic [TAG_W-1:0] tg  [NUM_REQ];

    function automatic int exp_grant(input logic [NUM_REQ-1:0] mask, input int ptr);
        int i;
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = (ptr + k) % NUM_REQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_filter[i*FW +: FW]       = flt[i];
            req_tag[i*TAG_W +: TAG_W]    = tg[i];
        end
    endtask

    // One complete job: offer mask, expect the model's grant, wait for response, apply bp cycles of backpressure.
    task automatic run_job(input logic [NUM_REQ-1:0] mask, input int n, input int bp, input int tag0);
        int                 g;
        int                 lat;
        int                 exp_lat;
        logic               exp_err;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [FW-1:0]      f;
        logic [TAG_W-1:0]   t;
        for (int i = 0; i < NUM_REQ; i++) begin
            flt[i] = FW'({$urandom, $urandom, $urandom});
            tg[i]  = TAG_W'($urandom);
        end
        if (tag0 >= 0) tg[0] = TAG_W'(tag0);
        drive_reqs();
        req_valid = mask;
        rsp_ready = 1'b0;
        done_n    = n;
        g         = exp_grant(mask, m_ptr);
        exp_rdy   = '0;
        exp_rdy[g] = 1'b1;
        f = flt[g];
        t = tg[g];
        exp_err = !(n > 0 && n <= TO);
        exp_lat = exp_err ? TO + 2 : n + 2;
        #1;
        check("idle_busy", busy, 0);
        check("idle_eng_rst", eng_rst, 1);
        check("grant_ready", req_ready, exp_rdy);
        step();
        m_ptr = g;
        req_valid[g] = 1'b0;
        check("load_eng_rst", eng_rst, 1);
        check("load_busy", busy, 1);
        check("load_ready", req_ready, 0);
        check("load_filter", eng_filter, f);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
            if (!rsp_valid) check("run_ready", req_ready, 0);
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, g);
        check("rsp_tag", rsp_tag, t);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_filter", eng_filter, f);
        check("rsp_eng_rst", eng_rst, 1);
        for (int c = 0; c < bp; c++) begin
            step();
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, g);
            check("bp_tag", rsp_tag, t);
            check("bp_err", rsp_err, exp_err);
            check("bp_ready", req_ready, 0);
            check("bp_eng_rst", eng_rst, 1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("back_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_filter = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        step();
        step();
        check("rst_ready", req_ready, 0);
        check("rst_eng_rst", eng_rst, 1);
        check("rst_filter", eng_filter, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // All requesters valid: grants rotate 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            run_job('1, 2, 0, -1);
            check("rr_order", m_ptr, j % NUM_REQ);
        end

        // Single job from requester 0, tag 5, done after 9 cycles -> latency 11.
        run_job(4'b0001, 9, 0, 5);

        // Backpressure for 5 cycles.
        run_job(4'b0110, 4, 5, -1);

        // Timeout, done on the timeout cycle (done wins), one past, then a normal job.
        run_job(4'b1000, 0, 1, -1);
        run_job(4'b0011, TO, 0, -1);
        run_job(4'b0101, TO + 1, 0, -1);
        run_job(4'b1111, 3, 0, -1);

        // Stale done held high: idle stays idle, new job still passes LOAD.
        force_done = 1'b1;
        req_valid  = '0;
        step();
        step();
        check("stale_idle", busy, 0);
        run_job(4'b1010, 1, 0, -1);
        force_done = 1'b0;

        // Reset mid-RUN drops the job and restores the pointer.
        for (int i = 0; i < NUM_REQ; i++) begin
            flt[i] = FW'({$urandom, $urandom, $urandom});
            tg[i]  = TAG_W'($urandom);
        end
        drive_reqs();
        done_n    = 0;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (4) step();
        check("mid_run_busy", busy, 1);
        reset = 1'b1;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_eng_rst", eng_rst, 1);
        check("mid_rst_filter", eng_filter, 0);
        reset = 1'b0;
        m_ptr = NUM_REQ - 1;
        run_job('1, 3, 0, -1);
        check("post_rst_grant", m_ptr, 0);

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            run_job(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)),
                    $urandom_range(0, TO + 4), $urandom_range(0, 3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
